// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and ISA constants for the cpu controller
package cpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG
   } state_t;

   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_ALU    = 3'b101;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   // Field view of the 16-bit instruction; imm8 overlays {rd, sh, rm}
   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] op;
      logic [2:0] rn;
      logic [2:0] rd;
      logic [1:0] sh;
      logic [2:0] rm;
   } instr_t;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// rtl/cpu_controller_instr_decoder.sv - combinational field split, sximm8 and class flags
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [15:0] ir_i,
   output instr_t      fields_o,
   output logic [15:0] sximm8_o,
   output logic        is_mov_imm_o,
   output logic        is_mov_reg_o,
   output logic        is_mvn_o,
   output logic        is_cmp_o,
   output logic        is_alu3_o,
   output logic        legal_o
);

   logic is_mov_grp;
   logic is_alu_grp;

   assign fields_o   = instr_t'(ir_i);
   assign sximm8_o   = sext8(ir_i[7:0]);

   assign is_mov_grp = (fields_o.opcode == OPC_MOV);
   assign is_alu_grp = (fields_o.opcode == OPC_ALU);

   assign is_mov_imm_o = is_mov_grp && (fields_o.op == OP_MOV_IMM);
   assign is_mov_reg_o = is_mov_grp && (fields_o.op == OP_MOV_REG);
   assign is_mvn_o     = is_alu_grp && (fields_o.op == ALU_NOTB);
   assign is_cmp_o     = is_alu_grp && (fields_o.op == ALU_SUB);
   // Two-operand ALU instructions that need both A and B read
   assign is_alu3_o    = is_alu_grp && (fields_o.op inside {ALU_ADD, ALU_SUB, ALU_AND});
   assign legal_o      = is_mov_imm_o | is_mov_reg_o | is_mvn_o | is_alu3_o;

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register and Moore control FSM driving the datapath
module cpu_controller
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr_in,
   input  logic        load_ir,
   input  logic        start,
   output logic [15:0] datapath_in,
   output logic        wb_sel,
   output logic [2:0]  w_addr,
   output logic        w_en,
   output logic [2:0]  r_addr,
   output logic        en_A,
   output logic        en_B,
   output logic [1:0]  shift_op,
   output logic        sel_A,
   output logic        sel_B,
   output logic [1:0]  ALU_op,
   output logic        en_C,
   output logic        en_status,
   output logic        w,
   output logic        illegal
);

   state_t      state_q;
   logic [15:0] ir_q, ir_d;
   logic        w_q, w_en_q, wb_sel_q, en_a_q, en_b_q, sel_a_q, en_c_q, en_status_q, illegal_q;
   logic [2:0]  w_addr_q, r_addr_q;
   logic [1:0]  shift_op_q, alu_op_q;

   instr_t      f;
   logic [15:0] sximm8;
   logic        is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu3, legal;

   instr_decoder u_dec (
      .ir_i         (ir_q),
      .fields_o     (f),
      .sximm8_o     (sximm8),
      .is_mov_imm_o (is_mov_imm),
      .is_mov_reg_o (is_mov_reg),
      .is_mvn_o     (is_mvn),
      .is_cmp_o     (is_cmp),
      .is_alu3_o    (is_alu3),
      .legal_o      (legal)
   );

   // IR only accepts a new word while idle
   assign ir_d = (state_q == S_WAIT && load_ir) ? instr_in : ir_q;

   // State and registered outputs; outputs are set for the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT;
         ir_q        <= '0;
         illegal_q   <= 1'b0;
         w_q         <= 1'b1;
         w_en_q      <= 1'b0;
         wb_sel_q    <= 1'b0;
         w_addr_q    <= '0;
         r_addr_q    <= '0;
         en_a_q      <= 1'b0;
         en_b_q      <= 1'b0;
         shift_op_q  <= '0;
         sel_a_q     <= 1'b0;
         alu_op_q    <= '0;
         en_c_q      <= 1'b0;
         en_status_q <= 1'b0;
      end else begin
         ir_q        <= ir_d;
         w_q         <= 1'b0;
         w_en_q      <= 1'b0;
         wb_sel_q    <= 1'b0;
         w_addr_q    <= '0;
         r_addr_q    <= '0;
         en_a_q      <= 1'b0;
         en_b_q      <= 1'b0;
         shift_op_q  <= '0;
         sel_a_q     <= 1'b0;
         alu_op_q    <= '0;
         en_c_q      <= 1'b0;
         en_status_q <= 1'b0;
         case (state_q)
            S_WAIT: begin
               if (start) begin
                  state_q   <= S_DECODE;
                  illegal_q <= 1'b0;
               end else begin
                  w_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (is_mov_imm) begin
                  state_q  <= S_WRITE_IMM;
                  w_addr_q <= f.rn;
                  wb_sel_q <= 1'b1;
                  w_en_q   <= 1'b1;
               end else if (is_mov_reg || is_mvn) begin
                  state_q  <= S_GET_B;
                  r_addr_q <= f.rm;
                  en_b_q   <= 1'b1;
               end else if (is_alu3) begin
                  state_q  <= S_GET_A;
                  r_addr_q <= f.rn;
                  en_a_q   <= 1'b1;
               end else begin
                  state_q   <= S_WAIT;
                  w_q       <= 1'b1;
                  illegal_q <= !legal;
               end
            end
            S_GET_A: begin
               state_q  <= S_GET_B;
               r_addr_q <= f.rm;
               en_b_q   <= 1'b1;
            end
            S_GET_B: begin
               state_q     <= S_EXEC;
               shift_op_q  <= f.sh;
               alu_op_q    <= is_mov_reg ? ALU_ADD : f.op;
               sel_a_q     <= is_mov_reg;
               en_status_q <= is_cmp;
               en_c_q      <= !is_cmp;
            end
            S_EXEC: begin
               if (is_cmp) begin
                  state_q <= S_WAIT;
                  w_q     <= 1'b1;
               end else begin
                  state_q  <= S_WRITE_REG;
                  w_addr_q <= f.rd;
                  w_en_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= S_WAIT;
               w_q     <= 1'b1;
            end
         endcase
      end
   end

   assign datapath_in = sximm8;
   assign wb_sel      = wb_sel_q;
   assign w_addr      = w_addr_q;
   assign w_en        = w_en_q;
   assign r_addr      = r_addr_q;
   assign en_A        = en_a_q;
   assign en_B        = en_b_q;
   assign shift_op    = shift_op_q;
   assign sel_A       = sel_a_q;
   assign sel_B       = 1'b0;
   assign ALU_op      = alu_op_q;
   assign en_C        = en_c_q;
   assign en_status   = en_status_q;
   assign w           = w_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr_in = '0;
   logic        load_ir = 1'b0;
   logic        start = 1'b0;
   logic [15:0] datapath_in;
   logic        wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status, w, illegal;
   logic [2:0]  w_addr, r_addr;
   logic [1:0]  shift_op, ALU_op;

   cpu_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_in    (instr_in),
      .load_ir     (load_ir),
      .start       (start),
      .datapath_in (datapath_in),
      .wb_sel      (wb_sel),
      .w_addr      (w_addr),
      .w_en        (w_en),
      .r_addr      (r_addr),
      .en_A        (en_A),
      .en_B        (en_B),
      .shift_op    (shift_op),
      .sel_A       (sel_A),
      .sel_B       (sel_B),
      .ALU_op      (ALU_op),
      .en_C        (en_C),
      .en_status   (en_status),
      .w           (w),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       w, w_en, en_a, en_b, en_c, en_st, ill;
      bit       chk_w, chk_r, chk_x;
      bit       wb_sel, sel_a;
      bit [2:0] w_addr, r_addr;
      bit [1:0] sh, alu;
   } exp_t;

   exp_t        q[$];
   logic [15:0] model_ir = '0;
   bit          model_illegal = 1'b0;
   int          pulses = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t busy();
      exp_t e;
      e = '{default: 0};
      return e;
   endfunction

   // Expected per-cycle outputs for one instruction, from the ISA rules
   task automatic plan(input logic [15:0] iw);
      exp_t e;
      bit [2:0] opc = iw[15:13];
      bit [1:0] op = iw[12:11];
      bit mov_imm = (opc == 3'b110) && (op == 2'b10);
      bit mov_reg = (opc == 3'b110) && (op == 2'b00);
      bit alu     = (opc == 3'b101);
      bit cmp     = alu && (op == 2'b01);
      bit needs_a = alu && (op != 2'b11);
      q.push_back(busy());
      if (mov_imm) begin
         e = busy(); e.chk_w = 1; e.w_en = 1; e.wb_sel = 1; e.w_addr = iw[10:8];
         q.push_back(e);
      end else if (mov_reg || alu) begin
         if (needs_a) begin
            e = busy(); e.chk_r = 1; e.en_a = 1; e.r_addr = iw[10:8];
            q.push_back(e);
         end
         e = busy(); e.chk_r = 1; e.en_b = 1; e.r_addr = iw[2:0];
         q.push_back(e);
         e = busy(); e.chk_x = 1; e.sh = iw[4:3];
         e.alu = mov_reg ? 2'b00 : op; e.sel_a = mov_reg;
         e.en_st = cmp; e.en_c = !cmp;
         q.push_back(e);
         if (!cmp) begin
            e = busy(); e.chk_w = 1; e.w_en = 1; e.wb_sel = 0; e.w_addr = iw[7:5];
            q.push_back(e);
         end
      end
      model_illegal = !(mov_imm || mov_reg || alu);
   endtask

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      exp_t e;
      chk("datapath_in", datapath_in, {{8{model_ir[7]}}, model_ir[7:0]});
      chk("sel_B", {15'd0, sel_B}, 16'd0);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("w", {15'd0, w}, {15'd0, e.w});
         chk("w_en", {15'd0, w_en}, {15'd0, e.w_en});
         chk("en_A", {15'd0, en_A}, {15'd0, e.en_a});
         chk("en_B", {15'd0, en_B}, {15'd0, e.en_b});
         chk("en_C", {15'd0, en_C}, {15'd0, e.en_c});
         chk("en_status", {15'd0, en_status}, {15'd0, e.en_st});
         chk("illegal_busy", {15'd0, illegal}, 16'd0);
         if (e.chk_w) begin
            chk("w_addr", {13'd0, w_addr}, {13'd0, e.w_addr});
            chk("wb_sel", {15'd0, wb_sel}, {15'd0, e.wb_sel});
         end
         if (e.chk_r) chk("r_addr", {13'd0, r_addr}, {13'd0, e.r_addr});
         if (e.chk_x) begin
            chk("shift_op", {14'd0, shift_op}, {14'd0, e.sh});
            chk("ALU_op", {14'd0, ALU_op}, {14'd0, e.alu});
            chk("sel_A", {15'd0, sel_A}, {15'd0, e.sel_a});
         end
      end else begin
         chk("idle_w", {15'd0, w}, 16'd1);
         chk("idle_enables", {11'd0, w_en, en_A, en_B, en_C, en_status}, 16'd0);
         chk("idle_illegal", {15'd0, illegal}, {15'd0, model_illegal});
      end
      if (w_en === 1'b1) pulses++;
   end

   // Issue one instruction and measure cycles until WAIT returns
   task automatic run(input logic [15:0] iw, input bit load, input int exp_lat,
                      input int exp_pulses, input bit poke);
      int lat;
      @(posedge clk); #1;
      instr_in = iw; load_ir = load; start = 1'b1;
      @(posedge clk); #1;
      load_ir = 1'b0; start = 1'b0; instr_in = 16'h0000;
      if (load) model_ir = iw;
      pulses = 0;
      plan(model_ir);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         lat = i;
         if (poke && i == 1) begin
            instr_in = 16'hFFFF; load_ir = 1'b1; start = 1'b1;
         end else begin
            instr_in = 16'h0000; load_ir = 1'b0; start = 1'b0;
         end
         if (w === 1'b1) break;
      end
      chk("latency", lat[15:0], exp_lat[15:0]);
      @(negedge clk);
      chk("wen_pulses", pulses[15:0], exp_pulses[15:0]);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_w", {15'd0, w}, 16'd1);
      chk("reset_illegal", {15'd0, illegal}, 16'd0);

      run(16'hD1FE, 1, 2, 1, 0);
      chk("sximm8_literal", datapath_in, 16'hFFFE);
      run(16'hA148, 1, 5, 1, 1);
      run(16'hA900, 1, 4, 0, 0);
      run(16'hC060, 1, 4, 1, 0);
      run(16'hB2E3, 1, 5, 1, 0);
      run(16'hB8B1, 1, 4, 1, 1);

      run(16'hE000, 1, 1, 0, 0);
      chk("illegal_set", {15'd0, illegal}, 16'd1);
      run(16'hD007, 1, 2, 1, 0);
      chk("illegal_clr", {15'd0, illegal}, 16'd0);
      chk("sximm8_pos", datapath_in, 16'h0007);

      // Separate load cycle, then start re-uses the latched IR
      @(posedge clk); #1;
      instr_in = 16'hD380; load_ir = 1'b1;
      @(posedge clk); #1;
      load_ir = 1'b0; instr_in = 16'h0000; model_ir = 16'hD380;
      run(16'h1234, 0, 2, 1, 0);
      chk("sximm8_neg", datapath_in, 16'hFF80);

      // Reset in GET_B of an ADD
      @(posedge clk); #1;
      instr_in = 16'hA148; load_ir = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      load_ir = 1'b0; start = 1'b0; instr_in = 16'h0000;
      model_ir = 16'hA148;
      plan(model_ir);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      model_ir = '0;
      model_illegal = 1'b0;
      pulses = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("reset_mid_pulses", pulses[15:0], 16'd0);
      chk("reset_mid_w", {15'd0, w}, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction register plus Moore control FSM that sits directly upstream of the datapath.
- Latches a 16-bit instruction and decodes it. Over a fixed sequence of cycles it drives every datapath control input (register-file read/write, A/B/C load enables, shift, ALU op, status load).
- Presents the sign-extended 8-bit immediate as the datapath's external write-back data.

Parameters:
- none (widths are fixed by the ISA; constants live in the package)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  16  instruction to latch
- load_ir  in  1  latch instr_in into IR (honoured only in WAIT)
- start  in  1  begin executing IR (honoured only in WAIT)
- datapath_in  out  16  sign-extended IR[7:0] (sximm8)
- wb_sel  out  1  1 = write datapath_in, 0 = write C
- w_addr  out  3  register-file write address
- w_en  out  1  register-file write enable
- r_addr  out  3  register-file read address
- en_A  out  1  load A
- en_B  out  1  load B
- shift_op  out  2  shifter op, passed from IR[4:3]
- sel_A  out  1  1 = force ALU A operand to 0
- sel_B  out  1  tied 0 (reserved)
- ALU_op  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
- en_C  out  1  load C
- en_status  out  1  load Z
- w  out  1  1 when idle in WAIT
- illegal  out  1  sticky flag: last decoded instruction was unsupported

Behaviour:
- IR fields:
  - [15:13] opcode
  - [12:11] op
  - [10:8] Rn
  - [7:5] Rd
  - [4:3] sh
  - [2:0] Rm
  - [7:0] imm8
- Supported instructions:
  - opcode 110, op 10: MOV Rn,#imm8
  - opcode 110, op 00: MOV Rd,Rm{,sh}
  - opcode 101, op 00: ADD
  - opcode 101, op 01: CMP
  - opcode 101, op 10: AND
  - opcode 101, op 11: MVN
  - every other encoding is illegal
- Reset (async, rst_n=0):
  - state=WAIT, IR=0, illegal=0
  - all enables 0, w=1
- Outputs:
  - All control outputs are a Moore function of state and IR.
  - Every enable is 0 in any state not listed below.
  - datapath_in is always sximm8, regardless of state.
- IR:
  - In WAIT, load_ir=1 loads IR on the edge.
  - load_ir together with start in the same cycle: the new IR is the one decoded.
  - load_ir and start are ignored in every state except WAIT.
- States:
  - WAIT: w=1. start → DECODE, and illegal is cleared on that edge.
  - DECODE:
    - MOV imm → WRITE_IMM
    - MOV reg or MVN → GET_B
    - ADD/CMP/AND → GET_A
    - illegal → WAIT, with illegal set to 1
  - WRITE_IMM: w_addr=Rn, wb_sel=1, w_en=1 → WAIT.
  - GET_A: r_addr=Rn, en_A=1 → GET_B.
  - GET_B: r_addr=Rm, en_B=1 → EXEC.
  - EXEC:
    - shift_op=sh
    - ALU_op=op, except MOV reg, which uses ALU_op=00 with sel_A=1
    - CMP: en_status=1, en_C=0 → WAIT
    - all others: en_C=1, en_status=0 → WRITE_REG
  - WRITE_REG: w_addr=Rd, wb_sel=0, w_en=1 → WAIT.
- Latency (cycles from the start edge until WAIT is re-entered):
  - MOV imm: 2
  - CMP: 4
  - MOV reg / MVN: 4
  - ADD / AND: 5
- w deasserts the cycle after start is sampled.
- Reset asserted mid-instruction: return to WAIT immediately; no further w_en pulse is issued.
- Exactly one w_en pulse per non-CMP legal instruction; none for CMP or illegal instructions.

Decomposition:
- cpu_pkg:
  - state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG)
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101
  - ALU op constants
  - instruction-field typedef struct
- Sub-module instr_decoder: combinational field extraction, sximm8 generation, and legal/class flags. Instantiated once; the FSM stays in cpu_controller.

Test Plan:
- Reset low mid-GET_B → state WAIT, w=1, all enables 0, illegal=0; no w_en after release.
- load_ir+start with 0xD1FE (MOV R1,#-2) → datapath_in=0xFFFE; one cycle with w_en=1, wb_sel=1, w_addr=1; w=1 two cycles after start.
- 0xA148 (ADD R2,R1,R0,LSL) → sequence:
  - GET_A: r_addr=1, en_A
  - GET_B: r_addr=0, en_B
  - EXEC: shift_op=01, ALU_op=00, en_C
  - WRITE_REG: w_addr=2, wb_sel=0
  - w=1 after 5 cycles
- 0xA900 (CMP R1,R0) → en_status=1 in EXEC, en_C=0, no w_en; WAIT after 4 cycles.
- 0xC060 (MOV R3,R0) → en_A never asserted; EXEC has sel_A=1, ALU_op=00; WRITE_REG w_addr=3.
- 0xE000 (illegal) → illegal=1 after DECODE, no enables, back in WAIT; next start with 0xD007 clears illegal. Pulsing start/load_ir while busy changes neither IR nor the sequence.
